// File: rtl/mem_stage.sv
// Memory stage of the five-stage MIPS pipeline: registers execute results,
// aligns/extends SRAM load data, and forwards the write-back value to decode.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [75:0] ex_to_mem_bus,
  input  logic [4:0]  load_sram_ex_data,
  input  logic [3:0]  data_ram_sel,
  input  logic [65:0] ex_hilo_bus,
  input  logic [31:0] data_sram_rdata,
  output logic [69:0] mem_to_wb_bus,
  output logic [37:0] mem_to_id_bus,
  output logic [65:0] mem_hilo_wb_bus,
  output logic        stallreq_for_mem
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HILO_W = 66;
  localparam int unsigned LOAD_W = 5;
  localparam int unsigned SEL_W  = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  ex_mem_t             ex_q, ex_d;
  logic [LOAD_W-1:0]   load_q, load_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [HILO_W-1:0]   hilo_q, hilo_d;
  logic [DATA_W-1:0]   rdata_hold_q, rdata_hold_d;
  logic                hold_valid_q, hold_valid_d;

  logic [DATA_W-1:0]   rd;
  logic [DATA_W-1:0]   load_result;
  logic [DATA_W-1:0]   rf_wdata;
  logic [7:0]          byte_sel;
  logic                byte_ok;
  logic [15:0]         half_sel;
  logic                half_ok;
  logic                is_lb, is_lbu, is_lh, is_lhu, is_lw;

  // Pipeline register next-state: bubble, capture, or hold (latching SRAM data once)
  always_comb begin
    ex_d         = ex_q;
    load_d       = load_q;
    sel_d        = sel_q;
    hilo_d       = hilo_q;
    rdata_hold_d = rdata_hold_q;
    hold_valid_d = hold_valid_q;
    if (stall[3] && !stall[4]) begin
      ex_d         = '0;
      load_d       = '0;
      sel_d        = '0;
      hilo_d       = '0;
      hold_valid_d = 1'b0;
    end else if (!stall[3]) begin
      ex_d         = ex_to_mem_bus;
      load_d       = load_sram_ex_data;
      sel_d        = data_ram_sel;
      hilo_d       = ex_hilo_bus;
      hold_valid_d = 1'b0;
    end else if (!hold_valid_q) begin
      rdata_hold_d = data_sram_rdata;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= '0;
      load_q       <= '0;
      sel_q        <= '0;
      hilo_q       <= '0;
      rdata_hold_q <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      ex_q         <= ex_d;
      load_q       <= load_d;
      sel_q        <= sel_d;
      hilo_q       <= hilo_d;
      rdata_hold_q <= rdata_hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign {is_lb, is_lbu, is_lh, is_lhu, is_lw} = load_q;

  // SRAM output is only trustworthy in the first cycle; afterwards use the latched copy
  assign rd = hold_valid_q ? rdata_hold_q : data_sram_rdata;

  always_comb begin
    byte_sel = 8'h00;
    byte_ok  = 1'b1;
    case (sel_q)
      4'b0001: byte_sel = rd[7:0];
      4'b0010: byte_sel = rd[15:8];
      4'b0100: byte_sel = rd[23:16];
      4'b1000: byte_sel = rd[31:24];
      default: byte_ok  = 1'b0;
    endcase
  end

  always_comb begin
    half_sel = 16'h0000;
    half_ok  = 1'b1;
    case (sel_q)
      4'b0011: half_sel = rd[15:0];
      4'b1100: half_sel = rd[31:16];
      default: half_ok  = 1'b0;
    endcase
  end

  always_comb begin
    load_result = '0;
    if (is_lw) begin
      load_result = rd;
    end else if (is_lb && byte_ok) begin
      load_result = {{24{byte_sel[7]}}, byte_sel};
    end else if (is_lbu && byte_ok) begin
      load_result = {24'h000000, byte_sel};
    end else if (is_lh && half_ok) begin
      load_result = {{16{half_sel[15]}}, half_sel};
    end else if (is_lhu && half_ok) begin
      load_result = {16'h0000, half_sel};
    end
  end

  assign rf_wdata = ex_q.sel_rf_res ? load_result : ex_q.ex_result;

  assign mem_to_id_bus    = {ex_q.rf_we, ex_q.rf_waddr, rf_wdata};
  assign mem_to_wb_bus    = {ex_q.pc, ex_q.rf_we, ex_q.rf_waddr, rf_wdata};
  assign mem_hilo_wb_bus  = hilo_q;
  assign stallreq_for_mem = 1'b0;

  // Store strobes and foreign stall bits are carried but not acted on here
  logic unused_bits;
  assign unused_bits = ^{ex_q.data_ram_en, ex_q.data_ram_wen, stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table with scoreboard queue plus
// hand-written stall, bubble, HI/LO and reset-during-hold sequences.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [75:0] ex_to_mem_bus;
  logic [4:0]  load_sram_ex_data;
  logic [3:0]  data_ram_sel;
  logic [65:0] ex_hilo_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_id_bus;
  logic [65:0] mem_hilo_wb_bus;
  logic        stallreq_for_mem;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] LD_LB  = 5'b10000;
  localparam logic [4:0] LD_LBU = 5'b01000;
  localparam logic [4:0] LD_LH  = 5'b00100;
  localparam logic [4:0] LD_LHU = 5'b00010;
  localparam logic [4:0] LD_LW  = 5'b00001;
  localparam logic [4:0] LD_NO  = 5'b00000;

  typedef struct {
    logic [31:0] pc;
    logic        is_store;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] ex_result;
    logic [4:0]  load;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[10];
  logic [69:0] sb[$];

  mem_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .ex_to_mem_bus     (ex_to_mem_bus),
    .load_sram_ex_data (load_sram_ex_data),
    .data_ram_sel      (data_ram_sel),
    .ex_hilo_bus       (ex_hilo_bus),
    .data_sram_rdata   (data_sram_rdata),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .mem_to_id_bus     (mem_to_id_bus),
    .mem_hilo_wb_bus   (mem_hilo_wb_bus),
    .stallreq_for_mem  (stallreq_for_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ex_to_mem_bus     = {v.pc, v.is_store, {4{v.is_store}}, v.sel_rf_res, v.rf_we, v.waddr, v.ex_result};
    load_sram_ex_data = v.load;
    data_ram_sel      = v.sel;
    data_sram_rdata   = v.rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [69:0] e;
    vec_t v;

    vecs[0] = '{32'hBFC00010, 1'b0, 1'b1, 1'b1, 5'd8,  32'h80000000, LD_LW,  4'b1111, 32'h12345678, 32'h12345678};
    vecs[1] = '{32'hBFC00014, 1'b0, 1'b1, 1'b1, 5'd9,  32'h80000002, LD_LB,  4'b0100, 32'h00F30000, 32'hFFFFFFF3};
    vecs[2] = '{32'hBFC00018, 1'b0, 1'b1, 1'b1, 5'd10, 32'h80000002, LD_LBU, 4'b0100, 32'h00F30000, 32'h000000F3};
    vecs[3] = '{32'hBFC0001C, 1'b0, 1'b1, 1'b1, 5'd11, 32'h80000002, LD_LH,  4'b1100, 32'h8001ABCD, 32'hFFFF8001};
    vecs[4] = '{32'hBFC00020, 1'b0, 1'b1, 1'b1, 5'd12, 32'h80000000, LD_LHU, 4'b0011, 32'h8001ABCD, 32'h0000ABCD};
    vecs[5] = '{32'hBFC00024, 1'b0, 1'b1, 1'b1, 5'd13, 32'h80000000, LD_LB,  4'b0001, 32'h00000080, 32'hFFFFFF80};
    vecs[6] = '{32'hBFC00028, 1'b0, 1'b1, 1'b1, 5'd14, 32'h80000003, LD_LBU, 4'b1000, 32'hFF7F0000, 32'h000000FF};
    vecs[7] = '{32'hBFC0002C, 1'b0, 1'b1, 1'b1, 5'd15, 32'h80000001, LD_LH,  4'b0110, 32'h8001ABCD, 32'h00000000};
    vecs[8] = '{32'hBFC00030, 1'b0, 1'b0, 1'b1, 5'd3,  32'h00001234, LD_NO,  4'b0000, 32'hCAFEF00D, 32'h00001234};
    vecs[9] = '{32'hBFC00034, 1'b1, 1'b0, 1'b0, 5'd0,  32'h80000040, LD_NO,  4'b1111, 32'h5A5A5A5A, 32'h80000040};

    rst = 1'b1;
    stall = 6'b0;
    ex_to_mem_bus = '0;
    load_sram_ex_data = '0;
    data_ram_sel = '0;
    ex_hilo_bus = '0;
    data_sram_rdata = 32'hFFFFFFFF;
    tick();
    tick();
    check("reset_wb",   mem_to_wb_bus, '0);
    check("reset_id",   70'(mem_to_id_bus), '0);
    check("reset_hilo", 70'(mem_hilo_wb_bus), '0);
    check("stallreq",   70'(stallreq_for_mem), '0);
    rst = 1'b0;

    // Table: one instruction per cycle, expected result popped one edge later
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i]);
      sb.push_back({vecs[i].pc, vecs[i].rf_we, vecs[i].waddr, vecs[i].exp_wdata});
      tick();
      e = sb.pop_front();
      check($sformatf("vec%0d_wb", i), mem_to_wb_bus, e);
      check($sformatf("vec%0d_id", i), 70'(mem_to_id_bus), 70'(e[37:0]));
    end

    // Load held across a stall while SRAM output changes
    v = '{32'hBFC00040, 1'b0, 1'b1, 1'b1, 5'd5, 32'h80000100, LD_LW, 4'b1111, 32'hAAAA5555, 32'hAAAA5555};
    drive(v);
    tick();
    check("hold_first", 70'(mem_to_wb_bus[31:0]), 70'(32'hAAAA5555));
    stall = 6'b011111;
    for (int c = 0; c < 3; c++) begin
      tick();
      data_sram_rdata = 32'hDEADBEEF;
      #1;
      check($sformatf("hold_c%0d", c), 70'(mem_to_wb_bus[31:0]), 70'(32'hAAAA5555));
    end
    stall = 6'b0;

    // Bubble: add waits upstream while this stage inserts a nop
    v = '{32'hBFC00050, 1'b0, 1'b0, 1'b1, 5'd3, 32'h00000007, LD_NO, 4'b0000, 32'h0, 32'h00000007};
    drive(v);
    stall = 6'b001111;
    tick();
    check("bubble_wb", mem_to_wb_bus, '0);
    check("bubble_id", 70'(mem_to_id_bus), '0);
    stall = 6'b0;
    tick();
    check("add_after", mem_to_wb_bus, {32'hBFC00050, 1'b1, 5'd3, 32'h00000007});

    // mthi passes through one cycle later
    ex_to_mem_bus = {32'hBFC00060, 44'h0};
    ex_hilo_bus = {1'b1, 1'b0, 32'h00000042, 32'h00000000};
    tick();
    check("hilo_bus", 70'(mem_hilo_wb_bus), 70'({1'b1, 1'b0, 32'h00000042, 32'h00000000}));
    check("hi_we", 70'(mem_hilo_wb_bus[65]), 70'(1'b1));

    // Reset mid-hold wins over stall and clears everything
    v = '{32'hBFC00070, 1'b0, 1'b1, 1'b1, 5'd7, 32'h80000200, LD_LW, 4'b1111, 32'h11112222, 32'h11112222};
    drive(v);
    ex_hilo_bus = {1'b0, 1'b1, 32'h0, 32'h00000099};
    tick();
    check("pre_rst", mem_to_wb_bus, {32'hBFC00070, 1'b1, 5'd7, 32'h11112222});
    stall = 6'b011111;
    tick();
    rst = 1'b1;
    tick();
    check("rst_hold_wb",   mem_to_wb_bus, '0);
    check("rst_hold_id",   70'(mem_to_id_bus), '0);
    check("rst_hold_hilo", 70'(mem_hilo_wb_bus), '0);
    rst = 1'b0;
    tick();
    check("post_rst_stalled", mem_to_wb_bus, '0);
    stall = 6'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
